coreriscv_axi4_grant_issuer: RTL and testbench

- Manager-side counterpart of the client finish unit: issues TileLink Grant messages toward a client and collects the returning Finish acknowledgements.
- Allocates manager_xact_id slots and streams multi-beat data grants with an addr_beat counter.
- Holds each slot busy until the matching Finish arrives.
- Sits between the outer-memory tracker (requests plus data beats) and the client Grant/Finish network ports.

---
 rtl/coreriscv_axi4_grant_issuer_pkg.sv | 50 +++++
 rtl/coreriscv_axi4_xact_id_pool.sv | 51 +++++
 rtl/coreriscv_axi4_grant_issuer.sv | 124 ++++++++++++
 tb/tb_coreriscv_axi4_grant_issuer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coreriscv_axi4_grant_issuer_pkg.sv
// Shared TileLink grant definitions: type codes, sizing, and grant-type classification helpers.
// The client finish unit reuses the same classification functions.
package coreriscv_axi4_grant_issuer_pkg;

   localparam int unsigned NBEATS   = 8;
   localparam int unsigned NXACT    = 4;
   localparam int unsigned BEAT_W   = $clog2(NBEATS);
   localparam int unsigned XID_W    = $clog2(NXACT);
   localparam int unsigned OCNT_W   = $clog2(NXACT + 1);
   localparam int unsigned GTYPE_W  = 4;
   localparam int unsigned CLIENT_W = 2;

   localparam logic [GTYPE_W-1:0] G_VOLUNTARY_ACK  = 4'd0;
   localparam logic [GTYPE_W-1:0] G_GET_DATA_BEAT  = 4'd4;
   localparam logic [GTYPE_W-1:0] G_GET_DATA_BLOCK = 4'd5;
   localparam logic [GTYPE_W-1:0] G_GRANT_SHARED   = 4'd0;

   typedef enum logic {ST_IDLE, ST_SEND} state_t;

   typedef struct packed {
      logic [CLIENT_W-1:0] client_id;
      logic                client_xact_id;
      logic                is_builtin_type;
      logic [GTYPE_W-1:0]  g_type;
   } grant_req_t;

   function automatic logic requires_ack(input logic is_builtin, input logic [GTYPE_W-1:0] g_type);
      return !(is_builtin && (g_type == G_VOLUNTARY_ACK));
   endfunction

   function automatic logic is_multibeat(input logic is_builtin, input logic [GTYPE_W-1:0] g_type);
      return is_builtin ? (g_type == G_GET_DATA_BLOCK) : (g_type == G_GRANT_SHARED);
   endfunction

   function automatic logic is_single_data(input logic is_builtin, input logic [GTYPE_W-1:0] g_type);
      return is_builtin && (g_type == G_GET_DATA_BEAT);
   endfunction

   function automatic logic has_data(input logic is_builtin, input logic [GTYPE_W-1:0] g_type);
      return is_multibeat(is_builtin, g_type) | is_single_data(is_builtin, g_type);
   endfunction

   function automatic logic [OCNT_W-1:0] popcount(input logic [NXACT-1:0] v);
      logic [OCNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < int'(NXACT); i++) n = n + OCNT_W'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/coreriscv_axi4_xact_id_pool.sv
// Manager transaction-id pool: busy bitmap, lowest-free allocation, release on Finish,
// registered occupancy count and a pulse when a Finish names an idle slot.
module coreriscv_axi4_xact_id_pool
   import coreriscv_axi4_grant_issuer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              alloc,
   input  logic              free,
   input  logic [XID_W-1:0]  free_id,
   output logic [XID_W-1:0]  alloc_id,
   output logic              any_free,
   output logic [OCNT_W-1:0] outstanding,
   output logic              free_error
);

   logic [NXACT-1:0] busy;
   logic [NXACT-1:0] busy_next;

   // Descending scan so the lowest free index wins.
   always_comb begin
      alloc_id = '0;
      any_free = 1'b0;
      for (int i = int'(NXACT) - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            alloc_id = XID_W'(i);
            any_free = 1'b1;
         end
      end
   end

   // Allocation sees the pre-release bitmap; it never targets a busy slot.
   always_comb begin
      busy_next = busy;
      if (free) busy_next[free_id] = 1'b0;
      if (alloc && any_free) busy_next[alloc_id] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy        <= '0;
         outstanding <= '0;
         free_error  <= 1'b0;
      end else begin
         busy        <= busy_next;
         outstanding <= popcount(busy_next);
         free_error  <= free && !busy[free_id];
      end
   end

endmodule

// File: rtl/coreriscv_axi4_grant_issuer.sv
// Manager-side Grant issuer: accepts grant requests, allocates manager_xact_id slots,
// streams single or multi-beat grants toward the client and retires slots on Finish.
module coreriscv_axi4_grant_issuer
   import coreriscv_axi4_grant_issuer_pkg::*;
#(
   parameter int unsigned MANAGER_ID = 0,
   parameter int unsigned DATA_W     = 64
) (
   input  logic                clk,
   input  logic                reset,
   output logic                io_req_ready,
   input  logic                io_req_valid,
   input  logic [1:0]          io_req_bits_client_id,
   input  logic                io_req_bits_client_xact_id,
   input  logic                io_req_bits_is_builtin_type,
   input  logic [3:0]          io_req_bits_g_type,
   output logic                io_data_ready,
   input  logic                io_data_valid,
   input  logic [DATA_W-1:0]   io_data_bits,
   input  logic                io_grant_ready,
   output logic                io_grant_valid,
   output logic [1:0]          io_grant_bits_header_src,
   output logic [1:0]          io_grant_bits_header_dst,
   output logic [2:0]          io_grant_bits_payload_addr_beat,
   output logic                io_grant_bits_payload_client_xact_id,
   output logic [1:0]          io_grant_bits_payload_manager_xact_id,
   output logic                io_grant_bits_payload_is_builtin_type,
   output logic [3:0]          io_grant_bits_payload_g_type,
   output logic [DATA_W-1:0]   io_grant_bits_payload_data,
   output logic                io_finish_ready,
   input  logic                io_finish_valid,
   input  logic [1:0]          io_finish_bits_manager_xact_id,
   output logic [2:0]          io_outstanding,
   output logic                io_finish_error
);

   state_t             state;
   grant_req_t         req;
   grant_req_t         hdr;
   logic [XID_W-1:0]   mxid;
   logic [BEAT_W-1:0]  beat;
   logic               hdr_has_data;
   logic               hdr_multibeat;
   logic               req_needs_ack;
   logic               req_fire;
   logic               grant_fire;
   logic [XID_W-1:0]   alloc_id;
   logic               any_free;
   logic               sending;

   assign req = '{client_id:       io_req_bits_client_id,
                  client_xact_id:  io_req_bits_client_xact_id,
                  is_builtin_type: io_req_bits_is_builtin_type,
                  g_type:          io_req_bits_g_type};

   assign req_needs_ack = requires_ack(req.is_builtin_type, req.g_type);
   assign sending       = (state == ST_SEND);
   assign io_req_ready  = !reset && (state == ST_IDLE) && (!req_needs_ack || any_free);
   assign req_fire      = io_req_valid && io_req_ready;

   // Data grants are paced by the data source; ack-only grants are offered unconditionally.
   assign io_grant_valid = sending && (hdr_has_data ? io_data_valid : 1'b1);
   assign io_data_ready  = sending && hdr_has_data && io_grant_ready;
   assign grant_fire     = io_grant_valid && io_grant_ready;

   assign io_grant_bits_header_src              = 2'(MANAGER_ID);
   assign io_grant_bits_header_dst              = hdr.client_id;
   assign io_grant_bits_payload_addr_beat       = beat;
   assign io_grant_bits_payload_client_xact_id  = hdr.client_xact_id;
   assign io_grant_bits_payload_manager_xact_id = mxid;
   assign io_grant_bits_payload_is_builtin_type = hdr.is_builtin_type;
   assign io_grant_bits_payload_g_type          = hdr.g_type;
   assign io_grant_bits_payload_data            = (sending && hdr_has_data) ? io_data_bits : '0;
   assign io_finish_ready                       = 1'b1;

   coreriscv_axi4_xact_id_pool u_pool (
      .clk         (clk),
      .reset       (reset),
      .alloc       (req_fire && req_needs_ack),
      .free        (io_finish_valid),
      .free_id     (io_finish_bits_manager_xact_id),
      .alloc_id    (alloc_id),
      .any_free    (any_free),
      .outstanding (io_outstanding),
      .free_error  (io_finish_error)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         hdr           <= '0;
         mxid          <= '0;
         beat          <= '0;
         hdr_has_data  <= 1'b0;
         hdr_multibeat <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_fire) begin
                  hdr           <= req;
                  mxid          <= req_needs_ack ? alloc_id : '0;
                  hdr_has_data  <= has_data(req.is_builtin_type, req.g_type);
                  hdr_multibeat <= is_multibeat(req.is_builtin_type, req.g_type);
                  beat          <= '0;
                  state         <= ST_SEND;
               end
            end
            ST_SEND: begin
               // Fields and beat index hold while the network back-pressures.
               if (grant_fire) begin
                  if (hdr_multibeat && (beat != BEAT_W'(NBEATS - 1))) begin
                     beat <= beat + BEAT_W'(1);
                  end else begin
                     beat  <= '0;
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_coreriscv_axi4_grant_issuer.sv
// Directed self-checking bench for the grant issuer: bursts, slot pool, no-ack grants,
// back-pressure, spurious finishes, reset mid-burst and back-to-back requests.
module tb_coreriscv_axi4_grant_issuer;

   logic        clk = 1'b0;
   logic        reset;
   logic        io_req_ready;
   logic        io_req_valid;
   logic [1:0]  io_req_bits_client_id;
   logic        io_req_bits_client_xact_id;
   logic        io_req_bits_is_builtin_type;
   logic [3:0]  io_req_bits_g_type;
   logic        io_data_ready;
   logic        io_data_valid;
   logic [63:0] io_data_bits;
   logic        io_grant_ready;
   logic        io_grant_valid;
   logic [1:0]  io_grant_bits_header_src;
   logic [1:0]  io_grant_bits_header_dst;
   logic [2:0]  io_grant_bits_payload_addr_beat;
   logic        io_grant_bits_payload_client_xact_id;
   logic [1:0]  io_grant_bits_payload_manager_xact_id;
   logic        io_grant_bits_payload_is_builtin_type;
   logic [3:0]  io_grant_bits_payload_g_type;
   logic [63:0] io_grant_bits_payload_data;
   logic        io_finish_ready;
   logic        io_finish_valid;
   logic [1:0]  io_finish_bits_manager_xact_id;
   logic [2:0]  io_outstanding;
   logic        io_finish_error;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   coreriscv_axi4_grant_issuer #(.MANAGER_ID(0), .DATA_W(64)) dut (
      .clk                                  (clk),
      .reset                                (reset),
      .io_req_ready                         (io_req_ready),
      .io_req_valid                         (io_req_valid),
      .io_req_bits_client_id                (io_req_bits_client_id),
      .io_req_bits_client_xact_id           (io_req_bits_client_xact_id),
      .io_req_bits_is_builtin_type          (io_req_bits_is_builtin_type),
      .io_req_bits_g_type                   (io_req_bits_g_type),
      .io_data_ready                        (io_data_ready),
      .io_data_valid                        (io_data_valid),
      .io_data_bits                         (io_data_bits),
      .io_grant_ready                       (io_grant_ready),
      .io_grant_valid                       (io_grant_valid),
      .io_grant_bits_header_src             (io_grant_bits_header_src),
      .io_grant_bits_header_dst             (io_grant_bits_header_dst),
      .io_grant_bits_payload_addr_beat      (io_grant_bits_payload_addr_beat),
      .io_grant_bits_payload_client_xact_id (io_grant_bits_payload_client_xact_id),
      .io_grant_bits_payload_manager_xact_id(io_grant_bits_payload_manager_xact_id),
      .io_grant_bits_payload_is_builtin_type(io_grant_bits_payload_is_builtin_type),
      .io_grant_bits_payload_g_type         (io_grant_bits_payload_g_type),
      .io_grant_bits_payload_data           (io_grant_bits_payload_data),
      .io_finish_ready                      (io_finish_ready),
      .io_finish_valid                      (io_finish_valid),
      .io_finish_bits_manager_xact_id       (io_finish_bits_manager_xact_id),
      .io_outstanding                       (io_outstanding),
      .io_finish_error                      (io_finish_error)
   );

   // Stimulus only: one accepted request of the given type, granted immediately.
   task automatic issue_single(input logic b, input logic [3:0] g);
      @(negedge clk);
      io_req_valid = 1'b1; io_req_bits_is_builtin_type = b; io_req_bits_g_type = g;
      io_data_valid = 1'b1; io_grant_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      io_req_valid = 1'b0;
      @(posedge clk);
   endtask

   // Stimulus only: one-cycle Finish for the given slot; returns at the following negedge.
   task automatic send_finish(input logic [1:0] id);
      @(negedge clk);
      io_finish_valid = 1'b1; io_finish_bits_manager_xact_id = id;
      @(posedge clk);
      @(negedge clk);
      io_finish_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      io_req_valid = 1'b0; io_req_bits_client_id = 2'd0; io_req_bits_client_xact_id = 1'b0;
      io_req_bits_is_builtin_type = 1'b0; io_req_bits_g_type = 4'd0;
      io_data_valid = 1'b0; io_data_bits = 64'd0; io_grant_ready = 1'b0;
      io_finish_valid = 1'b0; io_finish_bits_manager_xact_id = 2'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (io_grant_valid !== 1'b0) begin errors++; $display("FAIL rst_grant_valid got=%0b exp=0", io_grant_valid); end
      checks++; if (io_req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got=%0b exp=0", io_req_ready); end
      checks++; if (io_data_ready !== 1'b0) begin errors++; $display("FAIL rst_data_ready got=%0b exp=0", io_data_ready); end
      checks++; if (io_finish_ready !== 1'b1) begin errors++; $display("FAIL rst_finish_ready got=%0b exp=1", io_finish_ready); end
      checks++; if (io_outstanding !== 3'd0) begin errors++; $display("FAIL rst_outstanding got=%0d exp=0", io_outstanding); end
      checks++; if (io_finish_error !== 1'b0) begin errors++; $display("FAIL rst_finish_error got=%0b exp=0", io_finish_error); end
      checks++; if (io_grant_bits_payload_data !== 64'd0) begin errors++; $display("FAIL rst_data got=%h exp=0", io_grant_bits_payload_data); end
      reset = 1'b0;
      #1;
      checks++; if (io_req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_req_ready got=%0b exp=1", io_req_ready); end
   endtask

   task automatic test_multibeat();
      @(negedge clk);
      io_req_valid = 1'b1; io_req_bits_client_id = 2'd2; io_req_bits_client_xact_id = 1'b1;
      io_req_bits_is_builtin_type = 1'b1; io_req_bits_g_type = 4'd5;
      io_data_valid = 1'b1; io_grant_ready = 1'b1;
      #1;
      checks++; if (io_req_ready !== 1'b1) begin errors++; $display("FAIL mb_req_ready got=%0b exp=1", io_req_ready); end
      @(posedge clk);
      for (int b = 0; b < 8; b++) begin
         @(negedge clk);
         io_req_valid = 1'b0;
         io_data_bits = 64'hA000_0000_0000_0000 | 64'(b);
         #1;
         checks++; if (io_grant_valid !== 1'b1) begin errors++; $display("FAIL mb_valid beat=%0d got=%0b exp=1", b, io_grant_valid); end
         checks++; if (io_grant_bits_payload_addr_beat !== 3'(b)) begin errors++; $display("FAIL mb_addr_beat got=%0d exp=%0d", io_grant_bits_payload_addr_beat, b); end
         checks++; if (io_grant_bits_payload_manager_xact_id !== 2'd0) begin errors++; $display("FAIL mb_mxid got=%0d exp=0", io_grant_bits_payload_manager_xact_id); end
         checks++; if (io_grant_bits_payload_data !== (64'hA000_0000_0000_0000 | 64'(b))) begin errors++; $display("FAIL mb_data got=%h exp=%h", io_grant_bits_payload_data, 64'hA000_0000_0000_0000 | 64'(b)); end
         checks++; if (io_outstanding !== 3'd1) begin errors++; $display("FAIL mb_outstanding got=%0d exp=1", io_outstanding); end
         if (b == 0) begin
            checks++; if (io_grant_bits_header_dst !== 2'd2) begin errors++; $display("FAIL mb_dst got=%0d exp=2", io_grant_bits_header_dst); end
            checks++; if (io_grant_bits_header_src !== 2'd0) begin errors++; $display("FAIL mb_src got=%0d exp=0", io_grant_bits_header_src); end
            checks++; if (io_grant_bits_payload_client_xact_id !== 1'b1) begin errors++; $display("FAIL mb_cxid got=%0b exp=1", io_grant_bits_payload_client_xact_id); end
            checks++; if (io_grant_bits_payload_g_type !== 4'd5) begin errors++; $display("FAIL mb_gtype got=%0d exp=5", io_grant_bits_payload_g_type); end
         end
         @(posedge clk);
      end
      @(negedge clk);
      checks++; if (io_grant_valid !== 1'b0) begin errors++; $display("FAIL mb_end_valid got=%0b exp=0", io_grant_valid); end
      send_finish(2'd0);
      checks++; if (io_outstanding !== 3'd0) begin errors++; $display("FAIL mb_fin_outstanding got=%0d exp=0", io_outstanding); end
      checks++; if (io_finish_error !== 1'b0) begin errors++; $display("FAIL mb_fin_error got=%0b exp=0", io_finish_error); end
   endtask

   task automatic test_pool_full();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         io_req_valid = 1'b1; io_req_bits_is_builtin_type = 1'b1; io_req_bits_g_type = 4'd4;
         io_data_valid = 1'b1; io_grant_ready = 1'b1; io_data_bits = 64'h1000 + 64'(i);
         #1;
         checks++; if (io_req_ready !== 1'b1) begin errors++; $display("FAIL pool_req_ready i=%0d got=%0b exp=1", i, io_req_ready); end
         @(posedge clk);
         @(negedge clk);
         io_req_valid = 1'b0;
         #1;
         checks++; if (io_grant_bits_payload_manager_xact_id !== 2'(i)) begin errors++; $display("FAIL pool_mxid got=%0d exp=%0d", io_grant_bits_payload_manager_xact_id, i); end
         checks++; if (io_grant_bits_payload_data !== 64'h1000 + 64'(i)) begin errors++; $display("FAIL pool_data got=%h exp=%h", io_grant_bits_payload_data, 64'h1000 + 64'(i)); end
         @(posedge clk);
      end
      @(negedge clk);
      io_req_valid = 1'b1;
      #1;
      checks++; if (io_req_ready !== 1'b0) begin errors++; $display("FAIL pool_full_ready got=%0b exp=0", io_req_ready); end
      checks++; if (io_outstanding !== 3'd4) begin errors++; $display("FAIL pool_full_outstanding got=%0d exp=4", io_outstanding); end
      send_finish(2'd2);
      #1;
      checks++; if (io_req_ready !== 1'b1) begin errors++; $display("FAIL pool_released_ready got=%0b exp=1", io_req_ready); end
      checks++; if (io_outstanding !== 3'd3) begin errors++; $display("FAIL pool_released_outstanding got=%0d exp=3", io_outstanding); end
      @(posedge clk);
      @(negedge clk);
      io_req_valid = 1'b0;
      #1;
      checks++; if (io_grant_bits_payload_manager_xact_id !== 2'd2) begin errors++; $display("FAIL pool_reuse_mxid got=%0d exp=2", io_grant_bits_payload_manager_xact_id); end
      checks++; if (io_outstanding !== 3'd4) begin errors++; $display("FAIL pool_reuse_outstanding got=%0d exp=4", io_outstanding); end
      @(posedge clk);
   endtask

   task automatic test_no_ack_full();
      @(negedge clk);
      io_req_valid = 1'b1; io_req_bits_is_builtin_type = 1'b1; io_req_bits_g_type = 4'd0;
      io_data_valid = 1'b0; io_data_bits = 64'hFF; io_grant_ready = 1'b1;
      #1;
      checks++; if (io_req_ready !== 1'b1) begin errors++; $display("FAIL noack_req_ready got=%0b exp=1", io_req_ready); end
      @(posedge clk);
      @(negedge clk);
      io_req_valid = 1'b0;
      #1;
      checks++; if (io_grant_valid !== 1'b1) begin errors++; $display("FAIL noack_valid got=%0b exp=1", io_grant_valid); end
      checks++; if (io_grant_bits_payload_data !== 64'd0) begin errors++; $display("FAIL noack_data got=%h exp=0", io_grant_bits_payload_data); end
      checks++; if (io_grant_bits_payload_manager_xact_id !== 2'd0) begin errors++; $display("FAIL noack_mxid got=%0d exp=0", io_grant_bits_payload_manager_xact_id); end
      checks++; if (io_data_ready !== 1'b0) begin errors++; $display("FAIL noack_data_ready got=%0b exp=0", io_data_ready); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (io_grant_valid !== 1'b0) begin errors++; $display("FAIL noack_done_valid got=%0b exp=0", io_grant_valid); end
      checks++; if (io_outstanding !== 3'd4) begin errors++; $display("FAIL noack_outstanding got=%0d exp=4", io_outstanding); end
      for (int i = 0; i < 4; i++) send_finish(2'(i));
      checks++; if (io_outstanding !== 3'd0) begin errors++; $display("FAIL drain_outstanding got=%0d exp=0", io_outstanding); end
   endtask

   task automatic test_finish_error();
      issue_single(1'b1, 4'd4);
      send_finish(2'd3);
      checks++; if (io_finish_error !== 1'b1) begin errors++; $display("FAIL ferr_pulse got=%0b exp=1", io_finish_error); end
      checks++; if (io_outstanding !== 3'd1) begin errors++; $display("FAIL ferr_outstanding got=%0d exp=1", io_outstanding); end
      @(negedge clk);
      checks++; if (io_finish_error !== 1'b0) begin errors++; $display("FAIL ferr_one_cycle got=%0b exp=0", io_finish_error); end
      send_finish(2'd0);
      checks++; if (io_outstanding !== 3'd0) begin errors++; $display("FAIL ferr_release got=%0d exp=0", io_outstanding); end
      checks++; if (io_finish_error !== 1'b0) begin errors++; $display("FAIL ferr_valid_release got=%0b exp=0", io_finish_error); end
   endtask

   task automatic test_backpressure();
      int exp_beat = 0;
      int cyc = 0;
      @(negedge clk);
      io_req_valid = 1'b1; io_req_bits_is_builtin_type = 1'b0; io_req_bits_g_type = 4'd0;
      io_data_valid = 1'b1; io_grant_ready = 1'b0;
      @(posedge clk);
      while (exp_beat < 8 && cyc < 40) begin
         @(negedge clk);
         io_req_valid = 1'b0;
         io_grant_ready = (cyc % 2 == 0);
         io_data_bits = 64'hB00 + 64'(cyc);
         #1;
         checks++; if (io_grant_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got=%0b exp=1", cyc, io_grant_valid); end
         checks++; if (io_grant_bits_payload_addr_beat !== 3'(exp_beat)) begin errors++; $display("FAIL bp_addr_beat cyc=%0d got=%0d exp=%0d", cyc, io_grant_bits_payload_addr_beat, exp_beat); end
         checks++; if (io_grant_bits_payload_data !== 64'hB00 + 64'(cyc)) begin errors++; $display("FAIL bp_data got=%h exp=%h", io_grant_bits_payload_data, 64'hB00 + 64'(cyc)); end
         checks++; if (io_data_ready !== io_grant_ready) begin errors++; $display("FAIL bp_data_ready got=%0b exp=%0b", io_data_ready, io_grant_ready); end
         checks++; if (io_grant_bits_payload_manager_xact_id !== 2'd0) begin errors++; $display("FAIL bp_mxid got=%0d exp=0", io_grant_bits_payload_manager_xact_id); end
         @(posedge clk);
         if (io_grant_ready) exp_beat++;
         cyc++;
      end
      checks++; if (exp_beat != 8) begin errors++; $display("FAIL bp_timeout fires=%0d exp=8", exp_beat); end
      @(negedge clk);
      io_grant_ready = 1'b1;
      #1;
      checks++; if (io_grant_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got=%0b exp=0", io_grant_valid); end
      send_finish(2'd0);
   endtask

   task automatic test_reset_mid_burst();
      issue_single(1'b1, 4'd4);
      @(negedge clk);
      io_req_valid = 1'b1; io_req_bits_is_builtin_type = 1'b1; io_req_bits_g_type = 4'd5;
      io_data_valid = 1'b1; io_grant_ready = 1'b1;
      @(posedge clk);
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         io_req_valid = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      #1;
      checks++; if (io_grant_bits_payload_addr_beat !== 3'd3) begin errors++; $display("FAIL rmb_beat got=%0d exp=3", io_grant_bits_payload_addr_beat); end
      checks++; if (io_outstanding !== 3'd2) begin errors++; $display("FAIL rmb_outstanding got=%0d exp=2", io_outstanding); end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (io_grant_valid !== 1'b0) begin errors++; $display("FAIL rmb_valid got=%0b exp=0", io_grant_valid); end
      checks++; if (io_outstanding !== 3'd0) begin errors++; $display("FAIL rmb_cleared got=%0d exp=0", io_outstanding); end
      checks++; if (io_req_ready !== 1'b1) begin errors++; $display("FAIL rmb_idle_ready got=%0b exp=1", io_req_ready); end
      io_req_valid = 1'b1; io_req_bits_g_type = 4'd4;
      @(posedge clk);
      @(negedge clk);
      io_req_valid = 1'b0;
      #1;
      checks++; if (io_grant_bits_payload_manager_xact_id !== 2'd0) begin errors++; $display("FAIL rmb_next_mxid got=%0d exp=0", io_grant_bits_payload_manager_xact_id); end
      checks++; if (io_grant_bits_payload_addr_beat !== 3'd0) begin errors++; $display("FAIL rmb_next_beat got=%0d exp=0", io_grant_bits_payload_addr_beat); end
      @(posedge clk);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      io_req_valid = 1'b1; io_req_bits_is_builtin_type = 1'b1; io_req_bits_g_type = 4'd0;
      io_grant_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if (io_grant_valid !== 1'b1) begin errors++; $display("FAIL b2b_first got=%0b exp=1", io_grant_valid); end
      checks++; if (io_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_send_ready got=%0b exp=0", io_req_ready); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (io_grant_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap got=%0b exp=0", io_grant_valid); end
      checks++; if (io_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap_ready got=%0b exp=1", io_req_ready); end
      @(posedge clk);
      @(negedge clk);
      io_req_valid = 1'b0;
      checks++; if (io_grant_valid !== 1'b1) begin errors++; $display("FAIL b2b_second got=%0b exp=1", io_grant_valid); end
      checks++; if (io_outstanding !== 3'd1) begin errors++; $display("FAIL b2b_outstanding got=%0d exp=1", io_outstanding); end
      @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_multibeat();
      test_pool_full();
      test_no_ack_full();
      test_finish_error();
      test_backpressure();
      test_reset_mid_burst();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
